// File: rtl/sequential_divider.sv
// sequential_divider
// Unsigned restoring shift-and-subtract divider. One quotient bit is
// produced per clock; the controller FSM, iteration counter and the
// A (partial remainder) / Q (dividend -> quotient) / M (divisor)
// datapath all live in this block. The start/ready handshake matches the
// shift-and-add multiplier so both can hang off the same sequencer.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Controller states; kept as plain constants so the encoding matches
    // the multiplier's controller bit for bit.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WORKING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dbz_q, dbz_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. The extra top bit of the
    // difference is the borrow, which decides whether to keep or restore.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    // Trial subtraction for the current iteration.
    always_comb begin
        shifted = {a_q, q_q[WIDTH-1]};
        trial   = shifted - {1'b0, m_q};
        borrow  = trial[WIDTH];
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the
        // case leaves one unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (divisor != '0) begin
                        a_d     = '0;
                        q_d     = dividend;
                        m_d     = divisor;
                        count_d = CNT_LAST;
                        dbz_d   = 1'b0;
                        state_d = ST_WORKING;
                    end else begin
                        // Division by zero short-circuits: all-ones
                        // quotient, dividend returned as the remainder.
                        a_d     = dividend;
                        q_d     = '1;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WORKING: begin
                if (!borrow) begin
                    a_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end

                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would chain A/Q updates.
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs come straight from registers or a decode of the state
    // register, so there is no combinational path from any input.
    assign quotient    = q_q;
    assign remainder   = a_q;
    assign ready       = (state_q == ST_DONE);
    assign busy        = (state_q == ST_WORKING);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider
// Directed and randomized checks of the sequential divider at WIDTH=8.
// Expected results come from plain integer division in the bench.
module tb_sequential_divider;

    localparam int WIDTH = 8;
    localparam int BOUND = 40;

    logic             clock;
    logic             n_reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    sequential_divider #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division, with the divide-by-zero
    // convention of an all-ones quotient and the dividend as remainder.
    function automatic logic [WIDTH-1:0] ref_q(input int a, input int b);
        return (b == 0) ? {WIDTH{1'b1}} : WIDTH'(a / b);
    endfunction

    function automatic logic [WIDTH-1:0] ref_r(input int a, input int b);
        return (b == 0) ? WIDTH'(a) : WIDTH'(a % b);
    endfunction

    // Wait (bounded) for ready, counting edges after the accepting edge.
    // Optionally scrambles the operand inputs and pulses start while busy.
    task automatic wait_ready(output int lat, input bit scramble, input int poke_at);
        lat = 0;
        while (!ready && lat < BOUND) begin
            if (scramble) begin
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            start = (lat == poke_at);
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end
    endtask

    // Issue one division and check latency, handshake and results.
    task automatic run_div(input string tag, input int a, input int b, input bit scramble);
        int lat;
        int exp_lat;
        @(negedge clock);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        exp_lat = (b == 0) ? 0 : WIDTH;
        if (b != 0) begin
            check({tag, " busy_after_start"}, busy, 1);
            check({tag, " ready_after_start"}, ready, 0);
        end
        wait_ready(lat, scramble, -1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " quotient"}, quotient, ref_q(a, b));
        check({tag, " remainder"}, remainder, ref_r(a, b));
        check({tag, " div_by_zero"}, div_by_zero, (b == 0));
        check({tag, " busy_in_done"}, busy, 0);
    endtask

    initial begin
        int lat;
        int a;
        int b;

        n_reset  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset ready", ready, 0);
        check("reset busy", busy, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        @(negedge clock);
        n_reset = 1'b1;

        // Directed operand patterns and boundaries.
        run_div("100/7", 100, 7, 1'b0);
        run_div("255/1", 255, 1, 1'b0);
        run_div("5/9", 5, 9, 1'b0);
        run_div("255/255", 255, 255, 1'b0);
        run_div("0/3", 0, 3, 1'b0);
        run_div("42/0", 42, 0, 1'b0);

        // start pulsed during WORKING with new operands must be ignored.
        @(negedge clock);
        dividend = 8'd60;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = 8'd11;
        divisor  = 8'd3;
        wait_ready(lat, 1'b0, 3);
        check("ignore latency", lat, WIDTH);
        check("ignore quotient", quotient, 8);
        check("ignore remainder", remainder, 4);

        // Restart from DONE: ready must drop right after acceptance.
        run_div("200/13 from DONE", 200, 13, 1'b0);

        // DONE holds its result with start low.
        repeat (5) @(posedge clock);
        #1;
        check("hold ready", ready, 1);
        check("hold quotient", quotient, 15);
        check("hold remainder", remainder, 5);

        // Async reset in the middle of a division.
        @(negedge clock);
        dividend = 8'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort ready", ready, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort dbz", div_by_zero, 0);
        @(negedge clock);
        n_reset = 1'b1;
        run_div("9/2 after reset", 9, 2, 1'b0);

        // Randomized operands, with inputs scrambled while busy.
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_div($sformatf("rand%0d %0d/%0d", i, a, b), a, b, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
